// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types and constants for the PS/2 keyboard receiver
package ps2_pkg;
   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
endpackage

// File: rtl/ps2_sync_filter.sv
// rtl/ps2_sync_filter.sv - pin synchronisers, PS/2 clock deglitch filter and falling-edge strobe
module ps2_sync_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2_clk,
   input  logic ps2_dat,
   output logic fall,
   output logic dat
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
   localparam logic [FW-1:0] FLT_ONE  = FW'(1);

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          filt;
   logic [FW-1:0] cnt;

   // Counter tracks consecutive samples that disagree with the filtered level; any agreeing sample restarts it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         cnt      <= '0;
         fall     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_dat};
         fall     <= 1'b0;
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == FLT_LAST) begin
            filt <= clk_sync[1];
            cnt  <= '0;
            fall <= filt;
         end else begin
            cnt <= cnt + FLT_ONE;
         end
      end
   end

   assign dat = dat_sync[1];
endmodule

// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 frame receiver with scancode FIFO and space-key level tracker
module ps2_keyboard_rx
   import ps2_pkg::*;
#(
   parameter int         FILTER_LEN  = 8,
   parameter int         TIMEOUT_CYC = 100000,
   parameter int         FIFO_DEPTH  = 4,
   parameter logic [7:0] SPACE_CODE  = 8'h29
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iPS2_CLK,
   input  logic       iPS2_DAT,
   input  logic       iRD,
   output logic [7:0] oDATA,
   output logic       oEMPTY,
   output logic       oOVF,
   output logic       oERR,
   output logic       oSPACE
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_ONE   = TW'(1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   logic          fall;
   logic          dat;
   ps2_state_t    state;
   ps2_state_t    next_state;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          par_bit;
   logic [TW-1:0] tcnt;
   logic          timeout;
   logic          shift_en;
   logic          par_en;
   logic          good;
   logic          bad;
   logic          push_q;
   logic          err_q;
   logic [7:0]    byte_q;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          pop;
   logic          full;
   logic          push_ok;
   logic          ovf;
   logic          brk_pend;
   logic          ext_pend;
   logic          space;

   ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sync_filter (
      .clk     (iCLK),
      .rst_n   (iRST),
      .ps2_clk (iPS2_CLK),
      .ps2_dat (iPS2_DAT),
      .fall    (fall),
      .dat     (dat)
   );

   assign timeout = (tcnt == TO_LAST);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (fall && !dat) next_state = DATA;
         DATA:    if (fall && bit_cnt == 3'd7) next_state = PARITY;
                  else if (!fall && timeout) next_state = IDLE;
         PARITY:  if (fall) next_state = STOP;
                  else if (timeout) next_state = IDLE;
         STOP:    if (fall || timeout) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      shift_en = (state == DATA) && fall;
      par_en   = (state == PARITY) && fall;
      good     = (state == STOP) && fall && dat && ((^shreg) ^ par_bit);
      bad      = ((state == STOP) && fall && !good) ||
                 ((state != IDLE) && !fall && timeout);
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         shreg   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
         tcnt    <= '0;
         push_q  <= 1'b0;
         err_q   <= 1'b0;
         byte_q  <= '0;
      end else begin
         if (shift_en) shreg <= {dat, shreg[7:1]};
         if (state == IDLE) bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
         if (par_en) par_bit <= dat;
         if (state == IDLE || fall) tcnt <= '0;
         else tcnt <= tcnt + TO_ONE;
         push_q <= good;
         err_q  <= bad;
         if (good) byte_q <= shreg;
      end
   end

   // A push into a full FIFO still lands when a pop frees the head in the same cycle.
   assign full    = (count == CNT_FULL);
   assign pop     = iRD && (count != '0);
   assign push_ok = push_q && (!full || pop);

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= byte_q;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (push_q && full && !pop) ovf <= 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         brk_pend <= 1'b0;
         ext_pend <= 1'b0;
         space    <= 1'b0;
      end else if (push_q) begin
         if (byte_q == PS2_BREAK) begin
            brk_pend <= 1'b1;
         end else if (byte_q == PS2_EXT) begin
            ext_pend <= 1'b1;
         end else begin
            if (byte_q == SPACE_CODE && !ext_pend) space <= !brk_pend;
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
         end
      end else if (err_q) begin
         brk_pend <= 1'b0;
         ext_pend <= 1'b0;
      end
   end

   assign oDATA  = mem[rd_ptr];
   assign oEMPTY = (count == '0);
   assign oOVF   = ovf;
   assign oERR   = err_q;
   assign oSPACE = space;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - self-checking bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
   localparam int DEPTH = 4;
   localparam int TO    = 2000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ps2_clk = 1'b1;
   logic       ps2_dat = 1'b1;
   logic       rd = 1'b0;
   logic [7:0] data;
   logic       empty;
   logic       ovf;
   logic       err;
   logic       space;

   int total = 0;
   int bad = 0;
   int err_seen = 0;
   int err_exp = 0;
   bit quiet = 1'b0;

   logic [7:0] mq[$];
   bit m_ovf = 1'b0;
   bit m_space = 1'b0;
   bit m_brk = 1'b0;
   bit m_ext = 1'b0;

   ps2_keyboard_rx #(
      .FILTER_LEN  (8),
      .TIMEOUT_CYC (TO),
      .FIFO_DEPTH  (DEPTH),
      .SPACE_CODE  (8'h29)
   ) dut (
      .iCLK     (clk),
      .iRST     (rst_n),
      .iPS2_CLK (ps2_clk),
      .iPS2_DAT (ps2_dat),
      .iRD      (rd),
      .oDATA    (data),
      .oEMPTY   (empty),
      .oOVF     (ovf),
      .oERR     (err),
      .oSPACE   (space)
   );

   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   always @(negedge clk) begin
      if (err) err_seen++;
      if (quiet) begin
         total++;
         if (empty !== (mq.size() == 0) || ovf !== m_ovf || space !== m_space || err !== 1'b0 ||
             (mq.size() != 0 && data !== mq[0])) begin
            bad++;
            $display("FAIL model_cmp got empty=%0b data=%h ovf=%0b space=%0b err=%0b want empty=%0b head=%h ovf=%0b space=%0b err=0",
                     empty, data, ovf, space, err, mq.size() == 0, (mq.size() != 0) ? mq[0] : 8'h00,
                     m_ovf, m_space);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
   endtask

   task automatic m_good(input logic [7:0] d);
      if (mq.size() < DEPTH) mq.push_back(d);
      else m_ovf = 1'b1;
      if (d == 8'hF0) m_brk = 1'b1;
      else if (d == 8'hE0) m_ext = 1'b1;
      else begin
         if (d == 8'h29 && !m_ext) m_space = !m_brk;
         m_brk = 1'b0;
         m_ext = 1'b0;
      end
   endtask

   task automatic m_err();
      m_brk = 1'b0;
      m_ext = 1'b0;
      err_exp++;
   endtask

   task automatic frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                        input int nbits, input bit glitch);
      logic [10:0] b;
      b = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_dat = b[i];
         cyc(10);
         ps2_clk = 1'b0;
         if (glitch && i == 3) begin
            cyc(12); ps2_clk = 1'b1; cyc(3); ps2_clk = 1'b0; cyc(15);
         end else cyc(30);
         ps2_clk = 1'b1;
         if (glitch && i == 6) begin
            cyc(12); ps2_clk = 1'b0; cyc(3); ps2_clk = 1'b1; cyc(5);
         end else cyc(20);
      end
      ps2_dat = 1'b1;
   endtask

   task automatic settle();
      cyc(6);
      chk("err_count", err_seen, err_exp);
      quiet = 1'b1;
      cyc(3);
   endtask

   task automatic send_good(input logic [7:0] d, input bit glitch);
      quiet = 1'b0;
      frame(d, 1'b0, 1'b0, 11, glitch);
      m_good(d);
      settle();
   endtask

   task automatic send_bad(input logic [7:0] d, input logic bp, input logic bs);
      quiet = 1'b0;
      frame(d, bp, bs, 11, 1'b0);
      m_err();
      settle();
   endtask

   task automatic pop();
      @(negedge clk);
      rd = 1'b1;
      @(posedge clk);
      #1 rd = 1'b0;
      if (mq.size() > 0) void'(mq.pop_front());
   endtask

   task automatic pop_all();
      while (mq.size() > 0) pop();
   endtask

   initial begin
      cyc(4);
      @(negedge clk);
      chk("rst_empty", empty, 1);
      chk("rst_data", data, 8'h00);
      chk("rst_ovf", ovf, 0);
      chk("rst_err", err, 0);
      chk("rst_space", space, 0);
      rst_n = 1'b1;
      cyc(5);
      quiet = 1'b1;
      cyc(5);

      send_good(8'h1C, 1'b0);
      @(negedge clk);
      chk("1c_empty", empty, 0);
      chk("1c_data", data, 8'h1C);
      pop();
      @(negedge clk);
      chk("1c_popped", empty, 1);
      pop();

      send_bad(8'h1C, 1'b1, 1'b0);
      @(negedge clk);
      chk("parerr_empty", empty, 1);
      send_good(8'h32, 1'b0);
      @(negedge clk);
      chk("32_data", data, 8'h32);
      pop_all();

      send_good(8'h29, 1'b0);
      @(negedge clk);
      chk("space_make", space, 1);
      send_good(8'hF0, 1'b0); pop_all();
      send_good(8'h29, 1'b0); pop_all();
      @(negedge clk);
      chk("space_break", space, 0);
      send_good(8'h29, 1'b0); pop_all();
      send_good(8'hE0, 1'b0); pop_all();
      send_good(8'h29, 1'b0); pop_all();
      @(negedge clk);
      chk("space_ext_kept", space, 1);

      send_good(8'hF0, 1'b0); pop_all();
      send_bad(8'h77, 1'b0, 1'b1);
      send_good(8'h29, 1'b0); pop_all();
      @(negedge clk);
      chk("err_clears_brk", space, 1);

      send_good(8'h11, 1'b0);
      send_good(8'h22, 1'b0);
      send_good(8'h33, 1'b0);
      send_good(8'h44, 1'b0);
      send_good(8'h55, 1'b0);
      @(negedge clk);
      chk("ovf_set", ovf, 1);
      chk("ovf_head0", data, 8'h11); pop(); @(negedge clk);
      chk("ovf_head1", data, 8'h22); pop(); @(negedge clk);
      chk("ovf_head2", data, 8'h33); pop(); @(negedge clk);
      chk("ovf_head3", data, 8'h44); pop(); @(negedge clk);
      chk("ovf_drained", empty, 1);
      pop();
      @(negedge clk);
      chk("ovf_sticky", ovf, 1);

      quiet = 1'b0;
      frame(8'h0F, 1'b0, 1'b0, 5, 1'b0);
      cyc(TO + 300);
      m_err();
      settle();
      send_good(8'hA5, 1'b0);
      @(negedge clk);
      chk("after_timeout", data, 8'hA5);
      pop_all();

      send_good(8'h6B, 1'b1);
      @(negedge clk);
      chk("glitch_data", data, 8'h6B);

      quiet = 1'b0;
      frame(8'hC3, 1'b0, 1'b0, 4, 1'b0);
      rst_n = 1'b0;
      cyc(3);
      @(negedge clk);
      chk("midrst_empty", empty, 1);
      chk("midrst_ovf", ovf, 0);
      chk("midrst_space", space, 0);
      mq.delete();
      m_ovf = 1'b0; m_space = 1'b0; m_brk = 1'b0; m_ext = 1'b0;
      rst_n = 1'b1;
      cyc(5);
      send_good(8'h3C, 1'b0);
      @(negedge clk);
      chk("post_rst_data", data, 8'h3C);
      pop_all();
      cyc(5);
      quiet = 1'b0;
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
